thermal_array: RTL and testbench

THERMAL_ARRAY -- requirements
Module: thermal_array

---
 rtl/thermal_array.sv | 134 +++++++++++++
 tb/tb_thermal_array.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thermal_array.sv
// thermal_array: multi-channel first-order thermal model with per-channel alarms.
// Each update sweep steps every channel one at a time toward its steady-state
// target by 2^-alpha_shift of the remaining difference, then checks the alarm.
// One shared subtract/shift/add datapath serves all channels.
//
// Ports:
//   clk, rstN    - clock and asynchronous active-low reset
//   update_en    - single-cycle pulse that starts one sweep of all channels
//   T_steady     - per-channel target temperature, channel k at [k*WIDTH +: WIDTH]
//   alpha_shift  - per-channel shift, channel k at [k*SHIFT_W +: SHIFT_W]
//   T_alarm      - shared alarm set threshold
//   T_hyst       - shared alarm hysteresis band
//   ovr_clr      - clears the sticky overrun flag
//   T_current    - per-channel modelled temperature (registered)
//   alarm        - per-channel over-temperature flag (registered)
//   busy         - high while a sweep is in RUN or DONE
//   done         - one-cycle pulse in the DONE state
//   overrun      - sticky flag: an update_en pulse arrived while busy and was dropped
module thermal_array #(
    parameter int unsigned       WIDTH   = 16,
    parameter int unsigned       NCH     = 4,
    parameter int unsigned       SHIFT_W = 4,
    parameter logic [WIDTH-1:0]  T_INIT  = '0
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     update_en,
    input  logic [NCH*WIDTH-1:0]     T_steady,
    input  logic [NCH*SHIFT_W-1:0]   alpha_shift,
    input  logic [WIDTH-1:0]         T_alarm,
    input  logic [WIDTH-1:0]         T_hyst,
    input  logic                     ovr_clr,
    output logic [NCH*WIDTH-1:0]     T_current,
    output logic [NCH-1:0]           alarm,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;

    logic [WIDTH-1:0]   cur_t;
    logic [WIDTH-1:0]   tgt_t;
    logic [SHIFT_W-1:0] sh;
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] delta;
    logic [WIDTH-1:0]   new_t;
    logic [WIDTH-1:0]   alarm_lo;
    logic               alarm_new;
    logic               drop;

    // Shared datapath for the channel selected by idx
    always_comb begin
        cur_t     = T_current[idx*WIDTH +: WIDTH];
        tgt_t     = T_steady[idx*WIDTH +: WIDTH];
        sh        = alpha_shift[idx*SHIFT_W +: SHIFT_W];
        // Zero-extended operands: the WIDTH+1-bit signed difference cannot overflow
        diff      = $signed({1'b0, tgt_t}) - $signed({1'b0, cur_t});
        delta     = diff >>> sh;
        // Flooring never yields 0 for a negative diff, so only the +1 nudge is needed
        if ((diff != '0) && (delta == '0)) begin
            delta = {{WIDTH{1'b0}}, 1'b1};
        end
        new_t     = cur_t + delta[WIDTH-1:0];
        alarm_lo  = (T_alarm >= T_hyst) ? (T_alarm - T_hyst) : '0;
        alarm_new = alarm[idx];
        if (new_t >= T_alarm) begin
            alarm_new = 1'b1;
        end else if (new_t < alarm_lo) begin
            alarm_new = 1'b0;
        end
    end

    // A pulse that arrives while a sweep is in flight is discarded
    assign drop = update_en && (state != S_IDLE);

    // Sweep sequencer, channel state and status flags
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= S_IDLE;
            idx       <= '0;
            T_current <= {NCH{T_INIT}};
            alarm     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A new drop wins over a simultaneous clear
            overrun <= drop | (overrun & ~ovr_clr);
            case (state)
                S_IDLE: begin
                    if (update_en) begin
                        state <= S_RUN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    T_current[idx*WIDTH +: WIDTH] <= new_t;
                    alarm[idx]                    <= alarm_new;
                    if (idx == IDX_LAST) begin
                        state <= S_DONE;
                        idx   <= '0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thermal_array.sv
// Self-checking bench for thermal_array: directed vector table, hand-written
// multi-cycle sequences (hysteresis, overrun, reset mid-sweep) and random sweeps
// checked against an arithmetic reference model.
module tb_thermal_array;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NCH     = 4;
    localparam int unsigned SHIFT_W = 4;
    localparam logic [WIDTH-1:0] T_INIT = 16'h0000;

    logic                    clk;
    logic                    rstN;
    logic                    update_en;
    logic [NCH*WIDTH-1:0]    T_steady;
    logic [NCH*SHIFT_W-1:0]  alpha_shift;
    logic [WIDTH-1:0]        T_alarm;
    logic [WIDTH-1:0]        T_hyst;
    logic                    ovr_clr;
    logic [NCH*WIDTH-1:0]    T_current;
    logic [NCH-1:0]          alarm;
    logic                    busy;
    logic                    done;
    logic                    overrun;

    thermal_array #(
        .WIDTH   (WIDTH),
        .NCH     (NCH),
        .SHIFT_W (SHIFT_W),
        .T_INIT  (T_INIT)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .update_en   (update_en),
        .T_steady    (T_steady),
        .alpha_shift (alpha_shift),
        .T_alarm     (T_alarm),
        .T_hyst      (T_hyst),
        .ovr_clr     (ovr_clr),
        .T_current   (T_current),
        .alarm       (alarm),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model state and per-sweep stimulus
    int unsigned m_t [NCH];
    bit          m_a [NCH];
    int unsigned s_tgt [NCH];
    int unsigned s_sh  [NCH];

    typedef struct {
        int unsigned init;
        int unsigned tgt;
        int unsigned sh;
        int unsigned exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exponential step toward target with floor division and a minimum step of one
    function automatic int unsigned model_step(int unsigned cur, int unsigned tgt, int unsigned sh);
        int diff;
        int delta;
        int den;
        den  = 1 << sh;
        diff = int'(tgt) - int'(cur);
        if (diff >= 0) delta = diff / den;
        else           delta = -((-diff + den - 1) / den);
        if (delta == 0 && diff != 0) delta = (diff > 0) ? 1 : -1;
        return int'(cur) + delta;
    endfunction

    task automatic model_channel(input int k);
        int unsigned lo;
        int unsigned a;
        int unsigned h;
        a = int'(T_alarm);
        h = int'(T_hyst);
        m_t[k] = model_step(m_t[k], s_tgt[k], s_sh[k]);
        lo = (a >= h) ? a - h : 0;
        if (m_t[k] >= a)     m_a[k] = 1'b1;
        else if (m_t[k] < lo) m_a[k] = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NCH; k++) begin
            T_steady[k*WIDTH +: WIDTH]       = WIDTH'(s_tgt[k]);
            alpha_shift[k*SHIFT_W +: SHIFT_W] = SHIFT_W'(s_sh[k]);
        end
    endtask

    task automatic hold_targets();
        for (int k = 0; k < NCH; k++) begin
            s_tgt[k] = m_t[k];
            s_sh[k]  = 0;
        end
    endtask

    // One full sweep from IDLE, checking each channel at its write edge
    task automatic run_sweep();
        drive_inputs();
        update_en = 1'b1;
        @(negedge clk);
        update_en = 1'b0;
        chk("busy_start", 64'(busy), 64'd1);
        for (int k = 0; k < NCH; k++) begin
            model_channel(k);
            @(negedge clk);
            chk("ch_value", 64'(T_current[k*WIDTH +: WIDTH]), 64'(m_t[k]));
            chk("ch_alarm", 64'(alarm[k]), 64'(m_a[k]));
            chk("done_pulse", 64'(done), (k == NCH-1) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        chk("busy_end", 64'(busy), 64'd0);
        chk("done_end", 64'(done), 64'd0);
    endtask

    task automatic load_ch0(input int unsigned v);
        hold_targets();
        s_tgt[0] = v;
        run_sweep();
    endtask

    vec_t vecs [9];

    initial begin
        checks = 0;
        failures = 0;
        vecs[0] = '{init: 32'h0000, tgt: 32'h1000, sh: 8,  exp: 32'h0010};
        vecs[1] = '{init: 32'h00FF, tgt: 32'h0100, sh: 8,  exp: 32'h0100};
        vecs[2] = '{init: 32'h0101, tgt: 32'h0100, sh: 8,  exp: 32'h0100};
        vecs[3] = '{init: 32'hFFFF, tgt: 32'h0000, sh: 0,  exp: 32'h0000};
        vecs[4] = '{init: 32'h0000, tgt: 32'hFFFF, sh: 1,  exp: 32'h7FFF};
        vecs[5] = '{init: 32'h1000, tgt: 32'h0000, sh: 4,  exp: 32'h0F00};
        vecs[6] = '{init: 32'h0005, tgt: 32'h0000, sh: 15, exp: 32'h0004};
        vecs[7] = '{init: 32'h0005, tgt: 32'h0003, sh: 3,  exp: 32'h0004};
        vecs[8] = '{init: 32'h1234, tgt: 32'h1234, sh: 3,  exp: 32'h1234};

        rstN = 1'b0;
        update_en = 1'b0;
        ovr_clr = 1'b0;
        T_steady = '0;
        alpha_shift = '0;
        T_alarm = 16'hFFFF;
        T_hyst = 16'h0000;
        for (int k = 0; k < NCH; k++) begin
            m_t[k] = int'(T_INIT);
            m_a[k] = 1'b0;
        end
        #12;
        chk("rst_t", 64'(T_current), 64'({NCH{T_INIT}}));
        chk("rst_alarm", 64'(alarm), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Directed single-channel vectors on channel 0
        for (int i = 0; i < 9; i++) begin
            load_ch0(vecs[i].init);
            hold_targets();
            s_tgt[0] = vecs[i].tgt;
            s_sh[0]  = vecs[i].sh;
            run_sweep();
            chk("vec_result", 64'(T_current[WIDTH-1:0]), 64'(vecs[i].exp));
        end

        // Converged channel holds under repeated sweeps
        load_ch0(32'h0100);
        for (int i = 0; i < 2; i++) begin
            hold_targets();
            s_sh[0] = 8;
            run_sweep();
            chk("hold_0100", 64'(T_current[WIDTH-1:0]), 64'h0100);
        end

        // Hysteresis band
        T_alarm = 16'h8000;
        T_hyst  = 16'h0100;
        load_ch0(32'h8000); chk("hyst_set",   64'(alarm[0]), 64'd1);
        load_ch0(32'h7F80); chk("hyst_hold1", 64'(alarm[0]), 64'd1);
        load_ch0(32'h7EFF); chk("hyst_clear", 64'(alarm[0]), 64'd0);
        load_ch0(32'h7F00); chk("hyst_hold0", 64'(alarm[0]), 64'd0);
        // Hysteresis larger than threshold: lower bound saturates at zero
        T_alarm = 16'h0010;
        T_hyst  = 16'h0100;
        load_ch0(32'h0020); chk("sat_set",  64'(alarm[0]), 64'd1);
        load_ch0(32'h0000); chk("sat_hold", 64'(alarm[0]), 64'd1);

        // Overrun: second pulse during RUN is dropped
        hold_targets();
        drive_inputs();
        update_en = 1'b1;
        @(negedge clk);                  // E0
        update_en = 1'b0;
        @(negedge clk);                  // E1
        chk("ovr_before", 64'(overrun), 64'd0);
        update_en = 1'b1;
        @(negedge clk);                  // E2
        update_en = 1'b0;
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);       // E4
        chk("ovr_done", 64'(done), 64'd1);
        @(negedge clk);                  // E5
        chk("ovr_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("ovr_no_second", 64'(busy), 64'd0);
        for (int k = 0; k < NCH; k++) model_channel(k);

        // Simultaneous clear and drop keeps the flag
        update_en = 1'b1;
        @(negedge clk);
        update_en = 1'b0;
        @(negedge clk);
        update_en = 1'b1;
        ovr_clr = 1'b1;
        @(negedge clk);
        update_en = 1'b0;
        ovr_clr = 1'b0;
        chk("ovr_clr_drop", 64'(overrun), 64'd1);
        repeat (3) @(negedge clk);
        chk("ovr_idle2", 64'(busy), 64'd0);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_cleared", 64'(overrun), 64'd0);
        for (int k = 0; k < NCH; k++) model_channel(k);

        // Randomized sweeps against the model
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                T_alarm = WIDTH'($urandom_range(0, 65535));
                T_hyst  = WIDTH'($urandom_range(0, 4096));
            end
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 3) == 0)
                    s_tgt[k] = (m_t[k] + $urandom_range(0, 6) + 65533) % 65536;
                else
                    s_tgt[k] = $urandom_range(0, 65535);
                s_sh[k] = $urandom_range(0, 15);
            end
            run_sweep();
        end

        // Reset in the middle of a sweep
        for (int k = 0; k < NCH; k++) begin
            s_tgt[k] = 32'h1111 * (k + 1);
            s_sh[k]  = 0;
        end
        T_alarm = 16'h8000;
        T_hyst  = 16'h0100;
        drive_inputs();
        update_en = 1'b1;
        @(negedge clk);                  // E0
        update_en = 1'b0;
        repeat (2) @(negedge clk);       // E2
        chk("mid_ch1", 64'(T_current[WIDTH +: WIDTH]), 64'h2222);
        rstN = 1'b0;
        #1;
        chk("mid_rst_t", 64'(T_current), 64'({NCH{T_INIT}}));
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_alarm", 64'(alarm), 64'd0);
        for (int k = 0; k < NCH; k++) begin
            m_t[k] = int'(T_INIT);
            m_a[k] = 1'b0;
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < NCH + 2; i++) begin
            @(negedge clk);
            chk("mid_no_done", 64'(done), 64'd0);
        end
        chk("mid_hold_t", 64'(T_current), 64'({NCH{T_INIT}}));

        // update_en accepted on the first edge after reset release
        T_steady = '0;
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        update_en = 1'b1;
        @(negedge clk);
        update_en = 1'b0;
        chk("first_edge_busy", 64'(busy), 64'd1);
        repeat (NCH) @(negedge clk);
        chk("first_edge_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("first_edge_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
